// File: rtl/full_subtractor_reg.sv
// Ripple-borrow full subtractor built from chained 1-bit cells, with a
// registered copy of the result and a one-cycle valid strobe.

module full_subtractor_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   assign o_d    = i_a ^ i_b ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

module full_subtractor_reg #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Bin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic [WIDTH-1:0] d_q,
   output logic             bout_q,
   output logic             zero_q,
   output logic             out_valid
);

   logic [WIDTH:0]   w_br;
   logic             w_zero;
   logic [WIDTH-1:0] r_d;
   logic             r_bout;
   logic             r_zero;
   logic             r_valid;

   assign w_br[0] = Bin;

   // Borrow ripples LSB to MSB through one cell per bit.
   for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
      full_subtractor_cell u_cell (
         .i_a    (a[g]),
         .i_b    (b[g]),
         .i_bin  (w_br[g]),
         .o_d    (D[g]),
         .o_bout (w_br[g+1])
      );
   end

   assign Bout   = w_br[WIDTH];
   assign w_zero = (D == WIDTH'(0));

   // Capture register; result holds between strobes, valid pulses per capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d     <= WIDTH'(0);
         r_bout  <= 1'b0;
         r_zero  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_d    <= D;
            r_bout <= Bout;
            r_zero <= w_zero;
         end
      end
   end

   assign d_q       = r_d;
   assign bout_q    = r_bout;
   assign zero_q    = r_zero;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_full_subtractor_reg.sv
// Directed + random bench for full_subtractor_reg at WIDTH 1, 4 and 8,
// with a queue scoreboard for the registered 8-bit path.

module tb_full_subtractor_reg;

   typedef struct {
      logic [7:0] d;
      logic       bout;
      logic       zero;
   } exp8_t;

   logic       clk;
   logic       rst_n;

   logic       a1, b1, bin1, iv1;
   logic       d1, bo1, dq1, boq1, zq1, ov1;

   logic [3:0] a4, b4, d4, dq4;
   logic       bin4, iv4, bo4, boq4, zq4, ov4;

   logic [7:0] a8, b8, d8, dq8;
   logic       bin8, iv8, bo8, boq8, zq8, ov8;

   exp8_t      q8[$];
   exp8_t      l8;

   int         n_assert;
   int         n_fail;

   full_subtractor_reg #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .Bin(bin1), .in_valid(iv1),
      .D(d1), .Bout(bo1), .d_q(dq1), .bout_q(boq1), .zero_q(zq1), .out_valid(ov1)
   );

   full_subtractor_reg #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .Bin(bin4), .in_valid(iv4),
      .D(d4), .Bout(bo4), .d_q(dq4), .bout_q(boq4), .zero_q(zq4), .out_valid(ov4)
   );

   full_subtractor_reg #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .Bin(bin8), .in_valid(iv8),
      .D(d8), .Bout(bo8), .d_q(dq8), .bout_q(boq8), .zero_q(zq8), .out_valid(ov8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive 8-bit operands, check the combinational result, queue expected capture.
   task automatic drv8(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic v);
      logic [8:0] r;
      exp8_t      e;
      a8 = a; b8 = b; bin8 = bin; iv8 = v;
      r = {1'b0, a} - {1'b0, b} - {8'b0, bin};
      #1;
      chk("d8_comb", 32'(d8), 32'(r[7:0]));
      chk("bout8_comb", 32'(bo8), 32'(r[8]));
      if (v) begin
         e.d = r[7:0]; e.bout = r[8]; e.zero = (r[7:0] == 8'h00);
         q8.push_back(e);
      end
   endtask

   // After the next rising edge, compare registered outputs with the scoreboard.
   task automatic cmp8(input logic v);
      @(posedge clk);
      #1;
      chk("ov8", 32'(ov8), 32'(v));
      if (v) begin
         if (q8.size() == 0) begin
            chk("q8_empty", 32'(1), 32'(0));
         end else begin
            l8 = q8.pop_front();
         end
      end
      chk("dq8", 32'(dq8), 32'(l8.d));
      chk("boutq8", 32'(boq8), 32'(l8.bout));
      chk("zeroq8", 32'(zq8), 32'(l8.zero));
   endtask

   task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic v);
      @(negedge clk);
      drv8(a, b, bin, v);
      cmp8(v);
   endtask

   initial begin
      logic [1:0] r1;
      logic [7:0] sd;
      logic       sb;
      n_assert = 0;
      n_fail   = 0;
      l8 = '{d: 8'h00, bout: 1'b0, zero: 1'b0};
      rst_n = 1'b0;
      a1 = 0; b1 = 0; bin1 = 0; iv1 = 0;
      a4 = 0; b4 = 0; bin4 = 0; iv4 = 0;
      a8 = 0; b8 = 0; bin8 = 0; iv8 = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ov1", 32'(ov1), 32'(0));
      chk("rst_dq1", 32'(dq1), 32'(0));
      chk("rst_ov8", 32'(ov8), 32'(0));
      chk("rst_dq8", 32'(dq8), 32'(0));
      chk("rst_boq8", 32'(boq8), 32'(0));
      chk("rst_zq8", 32'(zq8), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: WIDTH=1 truth table, no capture
      for (int i = 0; i < 8; i++) begin
         {a1, b1, bin1} = 3'(i);
         r1 = {1'b0, a1} - {1'b0, b1} - {1'b0, bin1};
         #1;
         chk("d1_tt", 32'(d1), 32'(r1[0]));
         chk("bout1_tt", 32'(bo1), 32'(r1[1]));
      end
      @(posedge clk);
      #1;
      chk("t1_dq1_hold", 32'(dq1), 32'(0));
      chk("t1_ov1", 32'(ov1), 32'(0));

      // Test 2: WIDTH=1 single capture then idle
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0; iv1 = 1'b1;
      @(posedge clk);
      #1;
      chk("t2_dq1", 32'(dq1), 32'(1));
      chk("t2_boq1", 32'(boq1), 32'(0));
      chk("t2_zq1", 32'(zq1), 32'(0));
      chk("t2_ov1", 32'(ov1), 32'(1));
      @(negedge clk);
      iv1 = 1'b0;
      @(posedge clk);
      #1;
      chk("t2_ov1_low", 32'(ov1), 32'(0));
      chk("t2_dq1_hold", 32'(dq1), 32'(1));

      // Test 3: WIDTH=8 0 - FF - 1 wraps to zero with borrow
      step8(8'h00, 8'hFF, 1'b1, 1'b1);
      chk("t3_zq8", 32'(zq8), 32'(1));
      chk("t3_boq8", 32'(boq8), 32'(1));
      step8(8'hFF, 8'h00, 1'b0, 1'b1);
      step8(8'h5A, 8'h5A, 1'b1, 1'b1);

      // Test 4: random vectors with random capture strobe
      for (int i = 0; i < 1000; i++) begin
         step8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end

      // Test 5: asynchronous reset between edges while out_valid is high
      step8(8'h3C, 8'h11, 1'b0, 1'b1);
      #2;
      sd = d8;
      sb = bo8;
      drv8(8'h77, 8'h01, 1'b0, 1'b1);
      q8.delete();
      sd = d8;
      sb = bo8;
      rst_n = 1'b0;
      #1;
      chk("t5_ov8", 32'(ov8), 32'(0));
      chk("t5_dq8", 32'(dq8), 32'(0));
      chk("t5_boq8", 32'(boq8), 32'(0));
      chk("t5_zq8", 32'(zq8), 32'(0));
      chk("t5_d8_same", 32'(d8), 32'(sd));
      chk("t5_bout8_same", 32'(bo8), 32'(sb));
      l8 = '{d: 8'h00, bout: 1'b0, zero: 1'b0};
      @(posedge clk);
      #1;
      chk("t5_dq8_held_rst", 32'(dq8), 32'(0));
      chk("t5_ov8_held_rst", 32'(ov8), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      drv8(8'h10, 8'h20, 1'b0, 1'b1);
      cmp8(1'b1);
      step8(8'h00, 8'h00, 1'b0, 1'b0);

      // Test 6: WIDTH=4 a==b with and without borrow-in
      @(negedge clk);
      a4 = 4'h5; b4 = 4'h5; bin4 = 1'b1; iv4 = 1'b1;
      #1;
      chk("t6_d4_b1", 32'(d4), 32'(4'hF));
      chk("t6_bout4_b1", 32'(bo4), 32'(1));
      @(posedge clk);
      #1;
      chk("t6_dq4_b1", 32'(dq4), 32'(4'hF));
      chk("t6_boq4_b1", 32'(boq4), 32'(1));
      chk("t6_zq4_b1", 32'(zq4), 32'(0));
      @(negedge clk);
      bin4 = 1'b0;
      #1;
      chk("t6_d4_b0", 32'(d4), 32'(0));
      chk("t6_bout4_b0", 32'(bo4), 32'(0));
      @(posedge clk);
      #1;
      chk("t6_dq4_b0", 32'(dq4), 32'(0));
      chk("t6_boq4_b0", 32'(boq4), 32'(0));
      chk("t6_zq4_b0", 32'(zq4), 32'(1));
      chk("t6_ov4", 32'(ov4), 32'(1));
      @(negedge clk);
      iv4 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
